dram_line_ctrl: RTL and testbench
=================================

Name: dram_line_ctrl

Overview:
- Request-side controller that sits directly upstream of the single-port DRAM model.
- It takes whole cache-line read/write requests over a valid/ready handshake and serialises them into BEATS single-word DRAM accesses.
- Read beats are gathered into a line buffer, and one response per request is returned (read data or write ack) over a second valid/ready handshake.
- It is the single owner of the DRAM port.

Parameters:
- DATA, 32, DRAM word width in bits.
- ADDR, 28, DRAM word-address width.
- BEATS, 4, words per line; power of two, >= 2.
- BEAT_BITS, log2(BEATS), derived; not overridden.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  line request present
- req_ready  out  1  controller can accept a request
- req_wr  in  1  1 = line write, 0 = line read
- req_addr  in  ADDR-BEAT_BITS  line address
- req_data  in  BEATS*DATA  write line; beat i = bits [i*DATA +: DATA]
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_wr  out  1  echo of req_wr for this response
- resp_data  out  BEATS*DATA  read line (same beat packing); holds last read line on write acks
- mem_wr  out  1  DRAM write enable
- mem_addr  out  ADDR  DRAM word address = {line_reg, beat_cnt}
- mem_din  out  DATA  DRAM write data = beat beat_cnt of the write buffer
- mem_dout  in  DATA  DRAM registered read data, valid the cycle after address presented

Behaviour:
- Reset values: state = IDLE, beat_cnt = 0, line_reg = 0, wr_reg = 0, write buffer = 0, resp_data = 0.
  - Outputs after reset: req_ready = 1, resp_valid = 0, resp_wr = 0, mem_wr = 0, mem_addr = 0, mem_din = 0.
- Reset is honoured mid-operation: the FSM returns to IDLE and the in-flight request is dropped with no response. Beats already written stay in DRAM; there is no rollback.
- FSM states: IDLE, WRITE, READ, DRAIN, RESP.
- Combinational decodes:
  - req_ready = (state == IDLE).
  - mem_wr = (state == WRITE).
  - resp_valid = (state == RESP).
- IDLE:
  - On req_valid & req_ready: latch req_addr into line_reg, req_wr into wr_reg, and req_data into the write buffer; clear beat_cnt.
  - Next state is WRITE if req_wr, else READ.
- WRITE:
  - Each cycle drives mem_wr = 1, mem_addr = {line_reg, beat_cnt}, mem_din = buffer beat beat_cnt.
  - beat_cnt increments every cycle.
  - After beat BEATS-1, beat_cnt wraps to 0 and the FSM goes to RESP.
  - Occupies exactly BEATS cycles.
- READ:
  - Each cycle drives mem_addr = {line_reg, beat_cnt} with mem_wr = 0; beat_cnt increments.
  - In every READ cycle except the first, and in the DRAIN cycle, mem_dout is captured into resp_data beat (beat_cnt-1) mod BEATS. This accounts for the 1-cycle DRAM read latency.
  - After beat BEATS-1 the FSM goes to DRAIN.
- DRAIN:
  - Captures the last beat into resp_data beat BEATS-1; mem_wr = 0.
  - Goes to RESP.
- RESP:
  - resp_valid = 1; resp_wr = wr_reg; resp_data stable.
  - Holds until resp_ready; on resp_valid & resp_ready goes to IDLE.
- Latency, for a request accepted at edge T:
  - Write: DRAM writes at T+1..T+BEATS; resp_valid from cycle T+BEATS+1.
  - Read: addresses at T+1..T+BEATS; resp_valid from cycle T+BEATS+2.
- Throughput: a new request can be accepted at the earliest one cycle after the response handshake, because req_ready is not raised in the RESP cycle. There is no overlap of requests.
- resp_ready asserted outside RESP is ignored. req_valid outside IDLE is ignored, and the requester must hold it.
- Address arithmetic: beat_cnt is BEAT_BITS wide and wraps naturally. A line never crosses a line boundary, and the line address range wraps with no error.
- resp_data is never cleared except by reset. A write ack presents the previous read line and the consumer must ignore it.

Test Plan:
- Reset, then idle: req_ready = 1, resp_valid = 0, mem_wr = 0, mem_addr = 0 for 5 cycles; assert reset mid-READ → next cycle state IDLE, req_ready = 1, no response ever issued.
- Write line 0x10 with beats {0xA0,0xA1,0xA2,0xA3}, accepted at T: mem_wr = 1 with mem_addr = 0x40..0x43 and mem_din = 0xA0..0xA3 at T+1..T+4; resp_valid = 1, resp_wr = 1 at T+5.
- Read line 0x10 after that write (DRAM model attached): mem_addr = 0x40..0x43 at T+1..T+4, mem_wr = 0; resp_valid at T+6 with resp_data = {0xA3,0xA2,0xA1,0xA0} (beat 0 in LSBs).
- Backpressure: hold resp_ready = 0 for 7 cycles in RESP → resp_valid and resp_data stable, req_ready = 0, mem_wr = 0; release → IDLE next cycle, req_ready = 1.
- Back-to-back: req_valid held high with a read of line 0x3FFFFFF (top of range), then a write of line 0 → read addresses 0xFFFFFFC..0xFFFFFFF, second request accepted one cycle after the first response handshake, and no beat is dropped or duplicated.
- Random line reads and writes against a reference memory for 2000 requests → every read response matches the last write of that line; DRAM sees exactly BEATS accesses per request.

Source files
------------

// File: rtl/dram_line_ctrl.sv
// ============================================================================
//  Module   : dram_line_ctrl
//  Brief    : Cache-line request controller in front of a single-port DRAM.
//             Serialises line reads/writes into BEATS word accesses, gathers
//             read beats into a line buffer and returns one response per
//             request over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_line_ctrl #(
   parameter  int DATA      = 32,
   parameter  int ADDR      = 28,
   parameter  int BEATS     = 4,
   localparam int BEAT_BITS = $clog2(BEATS)
) (
   input  logic                        clk,
   input  logic                        reset,
   // line request channel
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_wr,
   input  logic [ADDR-BEAT_BITS-1:0]   req_addr,
   input  logic [BEATS*DATA-1:0]       req_data,
   // line response channel
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic                        resp_wr,
   output logic [BEATS*DATA-1:0]       resp_data,
   // DRAM port
   output logic                        mem_wr,
   output logic [ADDR-1:0]             mem_addr,
   output logic [DATA-1:0]             mem_din,
   input  logic [DATA-1:0]             mem_dout
);

   localparam logic [BEAT_BITS-1:0] c_BEAT_LAST = BEAT_BITS'(BEATS - 1);
   localparam logic [BEAT_BITS-1:0] c_BEAT_ONE  = BEAT_BITS'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [BEAT_BITS-1:0]         r_beat_cnt;
   logic [ADDR-BEAT_BITS-1:0]    r_line;
   logic                         r_wr;
   logic [BEATS*DATA-1:0]        r_wbuf;
   logic [BEATS*DATA-1:0]        r_rdata;

   logic                         w_accept;
   logic                         w_cap_en;
   logic [BEAT_BITS-1:0]         w_cap_idx;

   // DRAM read data lags the address by one cycle, so each capture lands in
   // the beat addressed on the previous cycle (wraps to BEATS-1 in DRAIN).
   assign w_cap_idx = r_beat_cnt - c_BEAT_ONE;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and per-state control decodes
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      mem_wr      = 1'b0;
      resp_valid  = 1'b0;
      w_accept    = 1'b0;
      w_cap_en    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = req_wr ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            mem_wr = 1'b1;
            if (r_beat_cnt == c_BEAT_LAST) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_READ: begin
            // first READ cycle has no returning data yet
            w_cap_en = (r_beat_cnt != '0);
            if (r_beat_cnt == c_BEAT_LAST) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_cap_en    = 1'b1;
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Request latching and beat counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_beat_cnt <= '0;
         r_line     <= '0;
         r_wr       <= 1'b0;
         r_wbuf     <= '0;
      end else if (w_accept) begin
         r_beat_cnt <= '0;
         r_line     <= req_addr;
         r_wr       <= req_wr;
         r_wbuf     <= req_data;
      end else if (r_state == ST_WRITE || r_state == ST_READ) begin
         // natural wrap returns the counter to 0 after the last beat
         r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
      end
   end

   // Read line buffer: gather returning DRAM words, otherwise hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (w_cap_en) begin
         for (int i = 0; i < BEATS; i++) begin
            if (w_cap_idx == BEAT_BITS'(i)) begin
               r_rdata[i*DATA +: DATA] <= mem_dout;
            end
         end
      end
   end

   // Write data beat select
   always_comb begin
      mem_din = '0;
      for (int i = 0; i < BEATS; i++) begin
         if (r_beat_cnt == BEAT_BITS'(i)) begin
            mem_din = r_wbuf[i*DATA +: DATA];
         end
      end
   end

   assign mem_addr  = {r_line, r_beat_cnt};
   assign resp_wr   = r_wr;
   assign resp_data = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dram_line_ctrl.sv
// ============================================================================
//  Module   : tb_dram_line_ctrl
//  Brief    : Self-checking bench for dram_line_ctrl with an attached DRAM
//             model and a line-level reference memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_line_ctrl;

   localparam int DATA  = 32;
   localparam int ADDR  = 28;
   localparam int BEATS = 4;
   localparam int LA    = 26;
   localparam int LW    = BEATS * DATA;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [LA-1:0]     req_addr;
   logic [LW-1:0]     req_data;
   logic              resp_valid;
   logic              resp_ready;
   logic              resp_wr;
   logic [LW-1:0]     resp_data;
   logic              mem_wr;
   logic [ADDR-1:0]   mem_addr;
   logic [DATA-1:0]   mem_din;
   logic [DATA-1:0]   mem_dout;

   int n_tests = 0;
   int n_fail  = 0;

   // Line-level reference: last data written to each line, last read line
   logic [LW-1:0]     ref_line [logic [LA-1:0]];
   logic [LW-1:0]     last_read;
   time               hs_time;

   logic [DATA-1:0]   dram [logic [ADDR-1:0]];

   dram_line_ctrl #(.DATA(DATA), .ADDR(ADDR), .BEATS(BEATS)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_wr    (resp_wr),
      .resp_data  (resp_data),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   always #5 clk = ~clk;

   // Single-port DRAM: registered read data, one-cycle latency
   always @(posedge clk) begin
      if (dram.exists(mem_addr)) mem_dout <= dram[mem_addr];
      else                       mem_dout <= '0;
      if (mem_wr) dram[mem_addr] = mem_din;
   end

   task automatic check_val(input string tag, input logic [LW-1:0] got,
                            input logic [LW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [LW-1:0] expected_line(input logic [LA-1:0] a);
      if (ref_line.exists(a)) return ref_line[a];
      return '0;
   endfunction

   // One full request: present, accept, check beats, response, backpressure,
   // handshake. Optionally leaves the next request presented with valid high.
   task automatic run_req(input logic wr, input logic [LA-1:0] a,
                          input logic [LW-1:0] d, input int hold,
                          input bit chk_gap,
                          input bit nxt, input logic nwr,
                          input logic [LA-1:0] na, input logic [LW-1:0] nd);
      int            g;
      time           acc_time;
      logic [LW-1:0] exp_data;
      logic [ADDR-1:0] exp_addr;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_data  = d;
      g = 0;
      while (!req_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      check_val("accept_wait", (g < 20), 1'b1);
      @(posedge clk);
      acc_time = $time;
      if (chk_gap) check_val("b2b_gap", acc_time - hs_time, 10);
      if (wr) begin
         exp_data = last_read;
         ref_line[a] = d;
      end else begin
         exp_data = expected_line(a);
      end
      for (int k = 0; k < BEATS; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if (nxt) begin
               req_wr   = nwr;
               req_addr = na;
               req_data = nd;
            end else begin
               req_valid = 1'b0;
            end
         end
         exp_addr = ADDR'(a) * ADDR'(BEATS) + ADDR'(k);
         check_val("beat_addr", mem_addr, exp_addr);
         check_val("beat_wr", mem_wr, wr);
         if (wr) check_val("beat_din", mem_din, d[k*DATA +: DATA]);
         check_val("beat_busy", {req_ready, resp_valid}, 2'b00);
      end
      if (!wr) begin
         @(negedge clk);
         check_val("drain", {resp_valid, mem_wr, req_ready}, 3'b000);
      end
      @(negedge clk);
      check_val("resp_valid", resp_valid, 1'b1);
      check_val("resp_wr", resp_wr, wr);
      check_val("resp_data", resp_data, exp_data);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_val("hold_valid", {resp_valid, req_ready, mem_wr}, 3'b100);
         check_val("hold_data", resp_data, exp_data);
      end
      if (!wr) last_read = exp_data;
      resp_ready = 1'b1;
      @(posedge clk);
      hs_time = $time;
      @(negedge clk);
      resp_ready = 1'b0;
      check_val("post_hs", {req_ready, resp_valid}, 2'b10);
   endtask

   function automatic logic [LA-1:0] rand_line();
      int r;
      r = $urandom_range(0, 19);
      if (r < 16)  return LA'(r);
      if (r == 16) return {LA{1'b1}};
      return LA'($urandom);
   endfunction

   function automatic logic [LW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic          pw, nw, nx;
      logic [LA-1:0] pa, na;
      logic [LW-1:0] pd, nd;
      int            nresp;

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_addr   = '0;
      req_data   = '0;
      resp_ready = 1'b0;
      last_read  = '0;
      hs_time    = 0;
      repeat (3) @(negedge clk);
      check_val("rst_outs", {req_ready, resp_valid, resp_wr, mem_wr}, 4'b1000);
      check_val("rst_mem", {mem_addr, mem_din}, '0);
      check_val("rst_rdata", resp_data, '0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("idle", {req_ready, resp_valid, mem_wr}, 3'b100);
         check_val("idle_addr", mem_addr, '0);
      end

      // directed write then read of line 0x10 with backpressure
      pd = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      run_req(1'b1, 26'h10, pd, 0, 1'b0, 1'b0, 1'b0, '0, '0);
      run_req(1'b0, 26'h10, '0, 7, 1'b1, 1'b0, 1'b0, '0, '0);
      check_val("rd_line10", last_read, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

      // back-to-back: read top line, then write line 0 with valid held high
      nd = rand_data();
      run_req(1'b0, {LA{1'b1}}, '0, 1, 1'b1, 1'b1, 1'b1, '0, nd);
      run_req(1'b1, '0, nd, 0, 1'b1, 1'b0, 1'b0, '0, '0);

      // reset in the middle of a read: request dropped, no response
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 26'h10;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("mid_rst_ready", {req_ready, resp_valid}, 2'b10);
      check_val("mid_rst_rdata", resp_data, '0);
      @(negedge clk);
      reset = 1'b0;
      last_read = '0;
      nresp = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp_valid) nresp++;
      end
      check_val("mid_rst_noresp", nresp, 0);

      // randomized traffic against the line reference
      pw = 1'($urandom_range(0, 1));
      pa = rand_line();
      pd = rand_data();
      for (int n = 0; n < 2000; n++) begin
         nw = 1'($urandom_range(0, 1));
         na = rand_line();
         nd = rand_data();
         nx = (n < 1999) ? 1'($urandom_range(0, 1)) : 1'b0;
         run_req(pw, pa, pd, $urandom_range(0, 3), (n > 0), nx, nw, na, nd);
         pw = nw;
         pa = na;
         pd = nd;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
